// File: rtl/zx_kbd_pkg.sv
// Shared types and tables for the PS/2 to ZX Spectrum keyboard matrix bridge:
// prefix FSM states, PS/2 prefix bytes and the logical-key to matrix-position map.
package zx_kbd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } kbd_state_e;

    localparam logic [7:0] CODE_E0 = 8'hE0;
    localparam logic [7:0] CODE_F0 = 8'hF0;
    localparam logic [7:0] CODE_E1 = 8'hE1;

    // Bytes swallowed after E1 (remainder of the Pause make sequence)
    localparam int PAUSE_SKIP = 7;

    // Keys 0..39 are the plain matrix keys, index = row*5 + col
    localparam int NDIRECT = 40;
    localparam int K_CS    = 0;
    localparam int K_SS    = 36;
    localparam int K_BKSP  = 40;
    localparam int K_COMMA = 41;
    localparam int K_DOT   = 42;
    localparam int K_SLASH = 43;
    localparam int K_SEMI  = 44;
    localparam int K_QUOTE = 45;
    localparam int K_MINUS = 46;
    localparam int K_EQUAL = 47;
    localparam int K_LEFT  = 48;
    localparam int K_DOWN  = 49;
    localparam int K_UP    = 50;
    localparam int K_RIGHT = 51;
    localparam int K_KPENT = 52;
    localparam int NKEYS   = 53;
    localparam int KEY_W   = $clog2(NKEYS);

    localparam int CS_R = 0;
    localparam int CS_C = 0;
    localparam int SS_R = 7;
    localparam int SS_C = 1;

    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [2:0] col;
    } pos_t;

    typedef struct packed {
        pos_t p0;
        pos_t p1;
    } key_pos_t;

    function automatic int key_rc(input int r, input int c);
        return r * 5 + c;
    endfunction

    function automatic pos_t mk_pos(input int r, input int c);
        pos_t p;
        p.valid = 1'b1;
        p.row   = 3'(r);
        p.col   = 3'(c);
        return p;
    endfunction

    function automatic key_pos_t key_positions(input logic [KEY_W-1:0] k);
        key_pos_t m;
        int       ki;
        m  = '0;
        ki = int'(k);
        if (ki < NDIRECT) begin
            m.p0 = mk_pos(ki / 5, ki % 5);
        end else begin
            case (ki)
                K_BKSP:  begin m.p0 = mk_pos(CS_R, CS_C); m.p1 = mk_pos(4, 0); end
                K_COMMA: begin m.p0 = mk_pos(SS_R, SS_C); m.p1 = mk_pos(7, 3); end
                K_DOT:   begin m.p0 = mk_pos(SS_R, SS_C); m.p1 = mk_pos(7, 2); end
                K_SLASH: begin m.p0 = mk_pos(SS_R, SS_C); m.p1 = mk_pos(0, 4); end
                K_SEMI:  begin m.p0 = mk_pos(SS_R, SS_C); m.p1 = mk_pos(5, 1); end
                K_QUOTE: begin m.p0 = mk_pos(SS_R, SS_C); m.p1 = mk_pos(4, 3); end
                K_MINUS: begin m.p0 = mk_pos(SS_R, SS_C); m.p1 = mk_pos(6, 3); end
                K_EQUAL: begin m.p0 = mk_pos(SS_R, SS_C); m.p1 = mk_pos(6, 1); end
                K_LEFT:  begin m.p0 = mk_pos(CS_R, CS_C); m.p1 = mk_pos(3, 4); end
                K_DOWN:  begin m.p0 = mk_pos(CS_R, CS_C); m.p1 = mk_pos(4, 4); end
                K_UP:    begin m.p0 = mk_pos(CS_R, CS_C); m.p1 = mk_pos(4, 3); end
                K_RIGHT: begin m.p0 = mk_pos(CS_R, CS_C); m.p1 = mk_pos(4, 2); end
                K_KPENT: begin m.p0 = mk_pos(6, 0); end
                default: ;
            endcase
        end
        return m;
    endfunction

    function automatic logic pos_hit(input key_pos_t m, input int r, input int c);
        return (m.p0.valid && int'(m.p0.row) == r && int'(m.p0.col) == c) ||
               (m.p1.valid && int'(m.p1.row) == r && int'(m.p1.col) == c);
    endfunction

endpackage

// File: rtl/zx_scan_decode.sv
// Combinational PS/2 set-2 scancode to logical ZX key lookup; ext selects
// the E0-prefixed table.
module zx_scan_decode
    import zx_kbd_pkg::*;
(
    input  logic [7:0]       code,
    input  logic             ext,
    output logic [KEY_W-1:0] key_idx,
    output logic             key_valid
);

    int k_sel;

    always_comb begin
        k_sel = -1;
        if (ext) begin
            case (code)
                8'h14:   k_sel = K_SS;
                8'h6B:   k_sel = K_LEFT;
                8'h72:   k_sel = K_DOWN;
                8'h75:   k_sel = K_UP;
                8'h74:   k_sel = K_RIGHT;
                8'h5A:   k_sel = K_KPENT;
                default: k_sel = -1;
            endcase
        end else begin
            case (code)
                8'h12: k_sel = K_CS;
                8'h1A: k_sel = key_rc(0, 1);
                8'h22: k_sel = key_rc(0, 2);
                8'h21: k_sel = key_rc(0, 3);
                8'h2A: k_sel = key_rc(0, 4);
                8'h1C: k_sel = key_rc(1, 0);
                8'h1B: k_sel = key_rc(1, 1);
                8'h23: k_sel = key_rc(1, 2);
                8'h2B: k_sel = key_rc(1, 3);
                8'h34: k_sel = key_rc(1, 4);
                8'h15: k_sel = key_rc(2, 0);
                8'h1D: k_sel = key_rc(2, 1);
                8'h24: k_sel = key_rc(2, 2);
                8'h2D: k_sel = key_rc(2, 3);
                8'h2C: k_sel = key_rc(2, 4);
                8'h16: k_sel = key_rc(3, 0);
                8'h1E: k_sel = key_rc(3, 1);
                8'h26: k_sel = key_rc(3, 2);
                8'h25: k_sel = key_rc(3, 3);
                8'h2E: k_sel = key_rc(3, 4);
                8'h45: k_sel = key_rc(4, 0);
                8'h46: k_sel = key_rc(4, 1);
                8'h3E: k_sel = key_rc(4, 2);
                8'h3D: k_sel = key_rc(4, 3);
                8'h36: k_sel = key_rc(4, 4);
                8'h4D: k_sel = key_rc(5, 0);
                8'h44: k_sel = key_rc(5, 1);
                8'h43: k_sel = key_rc(5, 2);
                8'h3C: k_sel = key_rc(5, 3);
                8'h35: k_sel = key_rc(5, 4);
                8'h5A: k_sel = key_rc(6, 0);
                8'h4B: k_sel = key_rc(6, 1);
                8'h42: k_sel = key_rc(6, 2);
                8'h3B: k_sel = key_rc(6, 3);
                8'h33: k_sel = key_rc(6, 4);
                8'h29: k_sel = key_rc(7, 0);
                8'h3A: k_sel = key_rc(7, 2);
                8'h31: k_sel = key_rc(7, 3);
                8'h32: k_sel = key_rc(7, 4);
                8'h66: k_sel = K_BKSP;
                8'h41: k_sel = K_COMMA;
                8'h49: k_sel = K_DOT;
                8'h4A: k_sel = K_SLASH;
                8'h4C: k_sel = K_SEMI;
                8'h52: k_sel = K_QUOTE;
                8'h4E: k_sel = K_MINUS;
                8'h55: k_sel = K_EQUAL;
                default: k_sel = -1;
            endcase
        end
        key_valid = (k_sel >= 0);
        key_idx   = key_valid ? KEY_W'(k_sel) : '0;
    end

endmodule

// File: rtl/zx_keymatrix.sv
// PS/2 keyboard to ZX Spectrum port 0xFE matrix: prefix FSM, per-key held bits
// and per-position press counters so overlapping combination keys release cleanly.
module zx_keymatrix
    import zx_kbd_pkg::*;
#(
    parameter int ROWS   = 8,
    parameter int COLS   = 5,
    parameter int CNT_W  = 2,
    parameter bit EXT_EN = 1'b1
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        ps2_data_clk,
    input  logic [7:0]  ps2_data,
    input  logic        clear,
    input  logic [15:0] A,
    output logic [7:0]  D,
    output logic        key_any,
    output logic        sat_err
);

    localparam logic [2:0]       SKIP_LAST = 3'(PAUSE_SKIP - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    kbd_state_e       state_q, state_d;
    logic [2:0]       skip_q, skip_d;
    logic [NKEYS-1:0] held_q, held_d;
    logic [CNT_W-1:0] cnt_q [ROWS][COLS];
    logic [CNT_W-1:0] cnt_d [ROWS][COLS];
    logic             sat_err_q, sat_err_d;

    logic [KEY_W-1:0] dec_key;
    logic             dec_valid;
    key_pos_t         kp;
    logic             is_ext, is_brk, is_prefix, decodes, do_make, do_break;
    logic             unused_addr;

    zx_scan_decode u_decode (
        .code      (ps2_data),
        .ext       (is_ext),
        .key_idx   (dec_key),
        .key_valid (dec_valid)
    );

    assign kp        = key_positions(dec_key);
    assign is_ext    = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    assign is_brk    = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
    assign is_prefix = ((state_q == ST_IDLE) &&
                        (ps2_data == CODE_E0 || ps2_data == CODE_F0 || ps2_data == CODE_E1)) ||
                       ((state_q == ST_EXT) && (ps2_data == CODE_F0));
    assign decodes   = ps2_data_clk && !clear && (state_q != ST_SKIP) && !is_prefix &&
                       dec_valid && (EXT_EN || !is_ext);
    // Typematic makes and stray breaks are filtered by the held bit
    assign do_make   = decodes && !is_brk && !held_q[dec_key];
    assign do_break  = decodes && is_brk && held_q[dec_key];

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        held_d    = held_q;
        cnt_d     = cnt_q;
        sat_err_d = sat_err_q;
        if (clear) begin
            state_d = ST_IDLE;
            skip_d  = '0;
            held_d  = '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    cnt_d[r][c] = '0;
                end
            end
        end else if (ps2_data_clk) begin
            case (state_q)
                ST_IDLE: begin
                    if (ps2_data == CODE_E0) begin
                        state_d = ST_EXT;
                    end else if (ps2_data == CODE_F0) begin
                        state_d = ST_BRK;
                    end else if (ps2_data == CODE_E1) begin
                        state_d = ST_SKIP;
                        skip_d  = '0;
                    end
                end
                ST_EXT: begin
                    state_d = (ps2_data == CODE_F0) ? ST_EXT_BRK : ST_IDLE;
                end
                ST_SKIP: begin
                    if (skip_q == SKIP_LAST) begin
                        state_d = ST_IDLE;
                        skip_d  = '0;
                    end else begin
                        skip_d = skip_q + 3'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (do_make) begin
                held_d[dec_key] = 1'b1;
            end
            if (do_break) begin
                held_d[dec_key] = 1'b0;
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (pos_hit(kp, r, c)) begin
                        if (do_make) begin
                            if (cnt_q[r][c] == CNT_MAX) sat_err_d = 1'b1;
                            else cnt_d[r][c] = cnt_q[r][c] + 1'b1;
                        end else if (do_break) begin
                            if (cnt_q[r][c] == '0) sat_err_d = 1'b1;
                            else cnt_d[r][c] = cnt_q[r][c] - 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            skip_q    <= '0;
            held_q    <= '0;
            sat_err_q <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    cnt_q[r][c] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            skip_q    <= skip_d;
            held_q    <= held_d;
            sat_err_q <= sat_err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Counters are zero during reset, so D and key_any idle without extra gating
    always_comb begin
        D       = 8'hFF;
        key_any = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (cnt_q[r][c] != '0) begin
                    key_any = 1'b1;
                    if (!A[8+r]) D[c] = 1'b0;
                end
            end
        end
    end

    assign sat_err     = sat_err_q;
    assign unused_addr = ^A[7:0];

endmodule

// File: tb/tb_zx_keymatrix.sv
// Self-checking bench for zx_keymatrix: directed scenarios plus random key
// traffic compared against an event-level model of the ZX matrix.
module tb_zx_keymatrix;

    logic        clock;
    logic        resetN;
    logic        ps2DataClk;
    logic [7:0]  ps2Data;
    logic        clear;
    logic [15:0] addr;
    logic [7:0]  dOut;
    logic        keyAny;
    logic        satErr;

    int checkCount;
    int passCount;

    zx_keymatrix dut (
        .CLOCK_50     (clock),
        .RESET_N      (resetN),
        .ps2_data_clk (ps2DataClk),
        .ps2_data     (ps2Data),
        .clear        (clear),
        .A            (addr),
        .D            (dOut),
        .key_any      (keyAny),
        .sat_err      (satErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Matrix picture: ext flag in bit 8, PS/2 code below, laid out as the ZX half-rows
    logic [8:0] matrixCode [8][5] = '{
        '{9'h012, 9'h01A, 9'h022, 9'h021, 9'h02A},
        '{9'h01C, 9'h01B, 9'h023, 9'h02B, 9'h034},
        '{9'h015, 9'h01D, 9'h024, 9'h02D, 9'h02C},
        '{9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E},
        '{9'h045, 9'h046, 9'h03E, 9'h03D, 9'h036},
        '{9'h04D, 9'h044, 9'h043, 9'h03C, 9'h035},
        '{9'h05A, 9'h04B, 9'h042, 9'h03B, 9'h033},
        '{9'h029, 9'h114, 9'h03A, 9'h031, 9'h032}
    };

    int         mCnt [8][5];
    bit         mHeld [512];
    bit         mSat;
    logic [8:0] keyList [$];

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic getPositions(input logic [8:0] kc, output int n,
                                output int r0, output int c0, output int r1, output int c1);
        n = 0; r0 = 0; c0 = 0; r1 = 0; c1 = 0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (matrixCode[r][c] == kc) begin
                    n = 1; r0 = r; c0 = c;
                end
            end
        end
        if (n == 0) begin
            n = 2;
            case (kc)
                9'h066: begin r0 = 0; c0 = 0; r1 = 4; c1 = 0; end
                9'h041: begin r0 = 7; c0 = 1; r1 = 7; c1 = 3; end
                9'h049: begin r0 = 7; c0 = 1; r1 = 7; c1 = 2; end
                9'h04A: begin r0 = 7; c0 = 1; r1 = 0; c1 = 4; end
                9'h04C: begin r0 = 7; c0 = 1; r1 = 5; c1 = 1; end
                9'h052: begin r0 = 7; c0 = 1; r1 = 4; c1 = 3; end
                9'h04E: begin r0 = 7; c0 = 1; r1 = 6; c1 = 3; end
                9'h055: begin r0 = 7; c0 = 1; r1 = 6; c1 = 1; end
                9'h16B: begin r0 = 0; c0 = 0; r1 = 3; c1 = 4; end
                9'h172: begin r0 = 0; c0 = 0; r1 = 4; c1 = 4; end
                9'h175: begin r0 = 0; c0 = 0; r1 = 4; c1 = 3; end
                9'h174: begin r0 = 0; c0 = 0; r1 = 4; c1 = 2; end
                9'h15A: begin r0 = 6; c0 = 0; n = 1; end
                default: n = 0;
            endcase
        end
    endtask

    task automatic modelBump(input int r, input int c, input bit up);
        if (up) begin
            if (mCnt[r][c] == 3) mSat = 1'b1;
            else mCnt[r][c]++;
        end else begin
            if (mCnt[r][c] == 0) mSat = 1'b1;
            else mCnt[r][c]--;
        end
    endtask

    task automatic modelEvent(input logic [8:0] kc, input bit brk);
        int n, r0, c0, r1, c1;
        getPositions(kc, n, r0, c0, r1, c1);
        if (n == 0) return;
        if (!brk && !mHeld[kc]) begin
            mHeld[kc] = 1'b1;
            modelBump(r0, c0, 1'b1);
            if (n == 2) modelBump(r1, c1, 1'b1);
        end else if (brk && mHeld[kc]) begin
            mHeld[kc] = 1'b0;
            modelBump(r0, c0, 1'b0);
            if (n == 2) modelBump(r1, c1, 1'b0);
        end
    endtask

    task automatic modelClear();
        for (int r = 0; r < 8; r++) for (int c = 0; c < 5; c++) mCnt[r][c] = 0;
        for (int i = 0; i < 512; i++) mHeld[i] = 1'b0;
    endtask

    function automatic logic [7:0] expectedD(input logic [15:0] a);
        logic [7:0] d;
        d = 8'hFF;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++)
                if (mCnt[r][c] > 0 && !a[8+r]) d[c] = 1'b0;
        return d;
    endfunction

    function automatic logic expectedAny();
        logic any;
        any = 1'b0;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 5; c++) if (mCnt[r][c] > 0) any = 1'b1;
        return any;
    endfunction

    task automatic sendByte(input logic [7:0] b, input int gap);
        for (int i = 0; i < gap; i++) begin
            @(negedge clock);
            ps2Data = 8'($urandom);
        end
        @(negedge clock);
        ps2Data    = b;
        ps2DataClk = 1'b1;
        @(negedge clock);
        ps2DataClk = 1'b0;
        ps2Data    = 8'($urandom);
    endtask

    task automatic applyStimulus(input logic [8:0] kc, input bit brk);
        if (kc[8]) sendByte(8'hE0, $urandom_range(0, 2));
        if (brk) sendByte(8'hF0, $urandom_range(0, 2));
        sendByte(kc[7:0], $urandom_range(0, 2));
        modelEvent(kc, brk);
    endtask

    task automatic checkD(input string tag, input logic [15:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        checkOutput(tag, 16'(dOut), 16'(exp));
    endtask

    task automatic doReset();
        @(negedge clock);
        resetN = 1'b0;
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        logic [7:0]  pauseSeq [8];
        logic [15:0] ra;
        checkCount = 0;
        passCount  = 0;
        resetN     = 1'b0;
        ps2DataClk = 1'b0;
        ps2Data    = 8'h00;
        clear      = 1'b0;
        addr       = 16'h0000;
        pauseSeq   = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        // Reset state, all rows selected
        repeat (3) @(negedge clock);
        checkD("reset_d", 16'h00FE, 8'hFF);
        checkOutput("reset_any", 16'(keyAny), 16'd0);
        checkOutput("reset_sat", 16'(satErr), 16'd0);
        resetN = 1'b1;
        @(negedge clock);

        // Single key make/break
        sendByte(8'h1C, 0);
        checkD("a_make", 16'hFDFE, 8'hFE);
        checkOutput("a_any", 16'(keyAny), 16'd1);
        sendByte(8'hF0, 0); sendByte(8'h1C, 0);
        checkD("a_break", 16'hFDFE, 8'hFF);

        // Shared SS position survives release of a combo
        sendByte(8'h41, 0);
        sendByte(8'hE0, 0); sendByte(8'h14, 0);
        sendByte(8'hF0, 0); sendByte(8'h41, 0);
        checkD("ss_held", 16'h7FFE, 8'hFD);
        sendByte(8'hE0, 0); sendByte(8'hF0, 0); sendByte(8'h14, 0);
        checkD("ss_rel", 16'h7FFE, 8'hFF);
        checkOutput("ss_any", 16'(keyAny), 16'd0);

        // Typematic repeats are absorbed
        repeat (5) sendByte(8'h1C, 1);
        checkD("typ_held", 16'hFDFE, 8'hFE);
        sendByte(8'hF0, 0); sendByte(8'h1C, 0);
        checkD("typ_rel", 16'hFDFE, 8'hFF);
        checkOutput("typ_sat", 16'(satErr), 16'd0);

        // Extended cursor key drives two rows
        sendByte(8'hE0, 0); sendByte(8'h75, 0);
        checkD("up_cs", 16'hFEFE, 8'hFE);
        checkD("up_7", 16'hEFFE, 8'hF7);
        sendByte(8'hE0, 0); sendByte(8'hF0, 0); sendByte(8'h75, 0);
        checkD("up_rel_cs", 16'hFEFE, 8'hFF);
        checkD("up_rel_7", 16'hEFFE, 8'hFF);

        // Pause sequence is swallowed
        foreach (pauseSeq[i]) sendByte(pauseSeq[i], 0);
        checkOutput("pause_any", 16'(keyAny), 16'd0);
        sendByte(8'h1C, 0);
        checkD("pause_after", 16'hFDFE, 8'hFE);
        sendByte(8'hF0, 0); sendByte(8'h1C, 0);

        // Clear beats a simultaneous strobe
        sendByte(8'h16, 0); sendByte(8'h1E, 0);
        checkD("pre_clear", 16'hF7FE, 8'hFC);
        @(negedge clock);
        clear = 1'b1; ps2Data = 8'h26; ps2DataClk = 1'b1;
        @(negedge clock);
        clear = 1'b0; ps2DataClk = 1'b0;
        checkD("clear_d", 16'h00FE, 8'hFF);
        checkOutput("clear_any", 16'(keyAny), 16'd0);
        sendByte(8'h26, 0);
        checkD("clear_idle", 16'hF7FE, 8'hFB);
        sendByte(8'hF0, 0); sendByte(8'h26, 0);

        // Clear mid-prefix: following byte decodes from IDLE
        sendByte(8'hF0, 0);
        @(negedge clock); clear = 1'b1;
        @(negedge clock); clear = 1'b0;
        sendByte(8'h1C, 0);
        checkD("clr_midbrk", 16'hFDFE, 8'hFE);
        sendByte(8'hF0, 0); sendByte(8'h1C, 0);

        // Reset mid-E0: 75 is then keypad 8, unmapped
        sendByte(8'hE0, 0);
        #2 resetN = 1'b0;
        #3 checkOutput("rst_any", 16'(keyAny), 16'd0);
        @(negedge clock); resetN = 1'b1;
        sendByte(8'h75, 0);
        checkOutput("rst_kp8", 16'(keyAny), 16'd0);
        checkD("rst_kp8_d", 16'h00FE, 8'hFF);

        // Saturation and underflow on the shared SS counter
        sendByte(8'hE0, 0); sendByte(8'h14, 0);
        sendByte(8'h41, 0); sendByte(8'h49, 0); sendByte(8'h4A, 0);
        checkOutput("sat_set", 16'(satErr), 16'd1);
        checkD("sat_row7", 16'h7FFE, 8'hF1);
        sendByte(8'hE0, 0); sendByte(8'hF0, 0); sendByte(8'h14, 0);
        sendByte(8'hF0, 0); sendByte(8'h41, 0);
        sendByte(8'hF0, 0); sendByte(8'h49, 0);
        checkD("sat_drain", 16'h7FFE, 8'hFF);
        checkD("sat_v", 16'hFEFE, 8'hEF);
        sendByte(8'hF0, 0); sendByte(8'h4A, 0);
        checkOutput("sat_empty", 16'(keyAny), 16'd0);

        // Random traffic against the model
        for (int r = 0; r < 8; r++) for (int c = 0; c < 5; c++) keyList.push_back(matrixCode[r][c]);
        keyList.push_back(9'h066); keyList.push_back(9'h041); keyList.push_back(9'h049);
        keyList.push_back(9'h04A); keyList.push_back(9'h04C); keyList.push_back(9'h052);
        keyList.push_back(9'h04E); keyList.push_back(9'h055); keyList.push_back(9'h16B);
        keyList.push_back(9'h172); keyList.push_back(9'h175); keyList.push_back(9'h174);
        keyList.push_back(9'h15A); keyList.push_back(9'h014); keyList.push_back(9'h075);
        keyList.push_back(9'h059); keyList.push_back(9'h112); keyList.push_back(9'h17C);
        doReset();
        modelClear();
        mSat = 1'b0;
        for (int n = 0; n < 300; n++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 4) begin
                @(negedge clock);
                clear = 1'b1; ps2DataClk = 1'($urandom_range(0, 1)); ps2Data = 8'($urandom);
                @(negedge clock);
                clear = 1'b0; ps2DataClk = 1'b0;
                modelClear();
            end else if (sel < 7) begin
                foreach (pauseSeq[i]) sendByte(pauseSeq[i], $urandom_range(0, 2));
            end else begin
                logic [8:0] kc;
                bit         brk;
                kc  = keyList[$urandom_range(0, keyList.size() - 1)];
                brk = mHeld[kc] ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
                applyStimulus(kc, brk);
            end
            ra = {8'($urandom), 8'hFE};
            checkD("rnd_d", ra, expectedD(ra));
            checkOutput("rnd_any", 16'(keyAny), 16'(expectedAny()));
            checkOutput("rnd_sat", 16'(satErr), 16'(mSat));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/zx_keymatrix.md
ZX_KEYMATRIX -- requirements
Module: zx_keymatrix

Interface
REQ-001 Parameter ROWS, default 8: number of ZX matrix half-rows, each selected by A[8+r].
REQ-002 Parameter COLS, default 5: keys per half-row, driven on D[COLS-1:0]; legal range 1..8.
REQ-003 Parameter CNT_W, default 2: width of the per-position press reference counter.
REQ-004 Parameter EXT_EN, default 1: when 1, E0-prefixed scancodes are decoded; when 0, they are ignored.
REQ-005 CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-006 RESET_N  in  1  asynchronous active-low reset.
REQ-007 ps2_data_clk  in  1  one-cycle strobe; ps2_data is valid while it is high.
REQ-008 ps2_data  in  8  received PS/2 set-2 byte.
REQ-009 clear  in  1  synchronous release-all request.
REQ-010 A  in  16  Z80 address bus; A[15:8] is the active-low half-row select.
REQ-011 D  out  8  port 0xFE keyboard data, active-low.
REQ-012 key_any  out  1  high while any matrix position is pressed.
REQ-013 sat_err  out  1  sticky flag; set when a counter saturates or underflows.

Function
REQ-014 Prefix FSM states are IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 then F0), and SKIP (after E1).
REQ-015 Transitions: IDLE -E0-> EXT; IDLE -F0-> BRK; EXT -F0-> EXT_BRK; IDLE -E1-> SKIP; any other byte in any state other than SKIP is decoded and returns the FSM to IDLE.
REQ-016 SKIP discards exactly 7 further bytes (the Pause sequence), then returns to IDLE.
REQ-017 A byte is consumed only on a cycle where ps2_data_clk is high; the FSM does not advance otherwise.
REQ-018 Each decoded code maps to a logical key k (0..NKEYS-1), which maps to one or two matrix positions; unmapped codes are ignored.
REQ-019 Each logical key has a held bit. Make with held[k]=0 sets held[k] and increments the counters of its positions.
REQ-020 Make with held[k]=1 (typematic repeat) has no effect.
REQ-021 Break with held[k]=1 clears held[k] and decrements the counters of its positions.
REQ-022 Break with held[k]=0 has no effect.
REQ-023 Counters saturate at 2^CNT_W-1 and floor at 0; either event sets sat_err.
REQ-024 A position counts as pressed when its counter is nonzero. Example: releasing ',' (SS+N) keeps SS pressed while RIGHT CTRL (SS) is still held.
REQ-025 Base map: ZX 40-key matrix from the Spectrum-standard PS/2 codes; L-SHIFT maps to CS and R-CTRL (E0 14) maps to SS.
REQ-026 Combination map: BKSP = CS+0; , = SS+N; . = SS+M; / = SS+V; ; = SS+O; ' = SS+7; - = SS+J; = = SS+L.
REQ-027 Extended map: E0 6B = CS+5, E0 72 = CS+6, E0 75 = CS+7, E0 74 = CS+8, E0 5A = ENTER; E0 12 and E0 7C are ignored.
REQ-028 D[c] = 0 if any row r with A[8+r]=0 has position (r,c) pressed; otherwise D[c] = 1.
REQ-029 D bits at index COLS and above always read 1; D is combinational from registered state and A.
REQ-030 Latency: a strobe in cycle n is reflected on D and key_any from cycle n+1.
REQ-031 clear zeroes all counters and held bits and returns the FSM to IDLE; clear wins over a simultaneous strobe.
REQ-032 A byte arriving mid-prefix after clear is decoded from IDLE.

Reset
REQ-033 RESET_N low asynchronously forces: FSM = IDLE, SKIP count = 0, all counters = 0, all held bits = 0, sat_err = 0.
REQ-034 While RESET_N is low: D = 8'hFF and key_any = 0.
REQ-035 Deassertion takes effect on the next CLOCK_50 edge; the first strobe after that is honoured.

Structure
REQ-036 Package zx_kbd_pkg holds: FSM state enum, prefix constants (E0, F0, E1), NKEYS, and the logical-key-to-position table (row/col pairs with valid bits).
REQ-037 Sub-module zx_scan_decode is purely combinational: inputs are code and ext; outputs are key index and a valid flag.
REQ-038 The top level holds the FSM, held bits, counters, and read logic.

Verification
REQ-039 Reset; send 1C, A=FDFE -> D=8'hFE; send F0 1C -> D=8'hFF.
REQ-040 Send 41 (,) then 14 with E0 prefix (R-CTRL), then F0 41 -> A=7FFE gives D=8'hFD (SS still pressed); then E0 F0 14 -> D=8'hFF.
REQ-041 Send 1C x5 (typematic), then F0 1C once -> D returns to 8'hFF and sat_err=0.
REQ-042 Send E0 75 -> A=FEFE gives D[0]=0 and A=EFFE gives D[3]=0; then E0 F0 75 -> both read 1.
REQ-043 Send E1 14 77 E1 F0 14 F0 77 -> no key pressed and FSM back in IDLE; a following 1C presses A.
REQ-044 Hold 16 and 1E, assert clear together with a strobe of 26 -> all D=8'hFF and key_any=0; assert RESET_N mid E0 -> next 75 decodes as keypad 8 (unmapped), no press.
